// File: rtl/midi_message_parser.sv
// MIDI byte-stream parser: decodes Note On/Off (with running status) and turns the
// note number into an oscillator playback rate, emitted as a one-cycle event.
module midi_message_parser #(
    parameter int CLK_HZ   = 100_000_000,
    parameter int WAVE_LEN = 64,
    parameter int CHANNEL  = 0,
    parameter int OMNI     = 1
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid_in,
    output logic        is_note_on_out,
    output logic [23:0] cycles_between_samples_out,
    output logic [6:0]  note_out,
    output logic [6:0]  velocity_out,
    output logic        valid_out
);

    // Rate for octave 10 of semitone s; lower octaves shift this left.
    // Reference pitch is 2^((120+s-69)/12) = 16 * 2^((s+3)/12) times A440.
    function automatic logic [31:0] base_rate(input int s);
        real ratio;
        real cyc;
        case (s)
            0:       ratio = 1.189207115002721;
            1:       ratio = 1.259921049894873;
            2:       ratio = 1.334839854170034;
            3:       ratio = 1.414213562373095;
            4:       ratio = 1.498307076876682;
            5:       ratio = 1.587401051968199;
            6:       ratio = 1.681792830507429;
            7:       ratio = 1.781797436280679;
            8:       ratio = 1.887748625363387;
            9:       ratio = 2.0;
            10:      ratio = 2.118926188726;
            11:      ratio = 2.244924096618746;
            default: ratio = 0.0;
        endcase
        if (ratio == 0.0) return 32'd0;
        cyc = $itor(CLK_HZ) / ($itor(WAVE_LEN) * 440.0 * 16.0 * ratio);
        return 32'($rtoi(cyc + 0.5));
    endfunction

    localparam logic [31:0] BASE [16] = '{
        base_rate(0),  base_rate(1),  base_rate(2),  base_rate(3),
        base_rate(4),  base_rate(5),  base_rate(6),  base_rate(7),
        base_rate(8),  base_rate(9),  base_rate(10), base_rate(11),
        32'd0, 32'd0, 32'd0, 32'd0
    };

    typedef enum logic [1:0] {NO_STATUS, EXPECT_D1, EXPECT_D2} state_t;

    state_t      state;
    logic [7:0]  status;
    logic [6:0]  d1;

    logic        vld_s1;
    logic [3:0]  semi_s1;
    logic [3:0]  oct_s1;
    logic [6:0]  note_s1;
    logic [6:0]  vel_s1;
    logic        on_s1;

    logic        is_data;
    logic        is_sys;
    logic        is_chan;
    logic        chan_ok;
    logic        note_evt;
    logic        evt_on;
    logic [47:0] wide;

    always_comb begin
        is_data  = byte_valid_in && !byte_in[7];
        is_sys   = byte_valid_in && (byte_in[7:3] == 5'b11110);
        is_chan  = byte_valid_in && byte_in[7] && (byte_in[7:4] != 4'hF);
        chan_ok  = (OMNI != 0) || (status[3:0] == 4'(CHANNEL));
        note_evt = is_data && (state == EXPECT_D2) && chan_ok &&
                   ((status[7:4] == 4'h8) || (status[7:4] == 4'h9));
        evt_on   = (status[7:4] == 4'h9) && (byte_in[6:0] != 7'd0);
    end

    // Real-time bytes (F8-FF) fall through every branch and leave state alone.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state   <= NO_STATUS;
            status  <= 8'd0;
            d1      <= 7'd0;
            vld_s1  <= 1'b0;
            semi_s1 <= 4'd0;
            oct_s1  <= 4'd0;
            note_s1 <= 7'd0;
            vel_s1  <= 7'd0;
            on_s1   <= 1'b0;
        end else begin
            vld_s1 <= note_evt;
            if (note_evt) begin
                semi_s1 <= 4'(d1 % 7'd12);
                oct_s1  <= 4'(d1 / 7'd12);
                note_s1 <= d1;
                vel_s1  <= byte_in[6:0];
                on_s1   <= evt_on;
            end
            if (is_chan) begin
                status <= byte_in;
                state  <= EXPECT_D1;
            end else if (is_sys) begin
                status <= 8'd0;
                state  <= NO_STATUS;
            end else if (is_data) begin
                case (state)
                    EXPECT_D1: begin
                        d1    <= byte_in[6:0];
                        // Program change / channel pressure carry a single data byte.
                        state <= (status[7:5] == 3'b110) ? EXPECT_D1 : EXPECT_D2;
                    end
                    EXPECT_D2: state <= EXPECT_D1;
                    default:   state <= NO_STATUS;
                endcase
            end
        end
    end

    always_comb wide = 48'(BASE[semi_s1]) << (4'd10 - oct_s1);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            valid_out                  <= 1'b0;
            is_note_on_out             <= 1'b0;
            cycles_between_samples_out <= 24'd0;
            note_out                   <= 7'd0;
            velocity_out               <= 7'd0;
        end else begin
            valid_out <= vld_s1;
            if (vld_s1) begin
                is_note_on_out             <= on_s1;
                cycles_between_samples_out <= (|wide[47:24]) ? 24'hFFFFFF : wide[23:0];
                note_out                   <= note_s1;
                velocity_out               <= vel_s1;
            end
        end
    end

endmodule

// File: tb/tb_midi_message_parser.sv
// Directed bench for midi_message_parser: an omni instance and a channel-2 filtered
// instance share one byte stream; expected rates are hand-computed constants.
module tb_midi_message_parser;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  byte_d = 8'd0;
    logic        bv = 1'b0;

    logic        on_o, f_on;
    logic [23:0] cyc_o, f_cyc;
    logic [6:0]  note_o, f_note;
    logic [6:0]  vel_o, f_vel;
    logic        vld_o, f_vld;

    int n_chk = 0;
    int n_pass = 0;
    int ev_cnt = 0;
    int f_cnt = 0;
    int c0, f0;

    midi_message_parser dut (
        .clk_in(clk), .rst_n_in(rst_n), .byte_in(byte_d), .byte_valid_in(bv),
        .is_note_on_out(on_o), .cycles_between_samples_out(cyc_o),
        .note_out(note_o), .velocity_out(vel_o), .valid_out(vld_o)
    );

    midi_message_parser #(.CHANNEL(2), .OMNI(0)) dut_f (
        .clk_in(clk), .rst_n_in(rst_n), .byte_in(byte_d), .byte_valid_in(bv),
        .is_note_on_out(f_on), .cycles_between_samples_out(f_cyc),
        .note_out(f_note), .velocity_out(f_vel), .valid_out(f_vld)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (vld_o) ev_cnt <= ev_cnt + 1;
        if (f_vld) f_cnt <= f_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic send(input logic [7:0] b);
        byte_d = b;
        bv = 1'b1;
        @(negedge clk);
        bv = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Called on the negedge right after the final data byte was clocked in.
    task automatic expect_event(input string tag, input logic on_e, input int note_e,
                                input int vel_e, input int cyc_e);
        chk({tag, " early"}, vld_o, 0);
        @(negedge clk);
        chk({tag, " valid"}, vld_o, 1);
        chk({tag, " on"}, on_o, on_e);
        chk({tag, " note"}, note_o, note_e);
        chk({tag, " vel"}, vel_o, vel_e);
        chk({tag, " rate"}, cyc_o, cyc_e);
        @(negedge clk);
        chk({tag, " pulse"}, vld_o, 0);
        chk({tag, " hold"}, note_o, note_e);
    endtask

    initial begin
        idle(2);
        chk("rst valid", vld_o, 0);
        chk("rst on", on_o, 0);
        chk("rst note", note_o, 0);
        chk("rst vel", vel_o, 0);
        chk("rst rate", cyc_o, 0);
        rst_n = 1'b1;
        idle(1);

        send(8'h90); send(8'h3C); send(8'h64);
        expect_event("c4 on", 1, 60, 100, 5984);

        send(8'h90); send(8'h45); send(8'h40);
        expect_event("a4 on", 1, 69, 64, 3552);
        send(8'h45); send(8'h00);
        expect_event("a4 vel0 off", 0, 69, 0, 3552);

        send(8'h80); send(8'h00); send(8'h10);
        expect_event("note0 off", 0, 0, 16, 191488);
        send(8'h90); send(8'h7F); send(8'h01);
        expect_event("note127 on", 1, 127, 1, 125);

        idle(1);
        c0 = ev_cnt;
        send(8'h90); send(8'h3C); send(8'hF8); send(8'h64);
        expect_event("rt interleave", 1, 60, 100, 5984);
        idle(2);
        chk("rt single event", ev_cnt - c0, 1);

        c0 = ev_cnt;
        send(8'hF0); send(8'h3C); send(8'h64); send(8'h3C); send(8'h64);
        idle(4);
        chk("sysex clears status", ev_cnt - c0, 0);

        c0 = ev_cnt;
        send(8'hB0); send(8'h07); send(8'h7F); send(8'hD0); send(8'h30); send(8'h31);
        idle(4);
        chk("cc/pressure discard", ev_cnt - c0, 0);

        c0 = ev_cnt;
        send(8'h90); send(8'h40); send(8'h50); send(8'h41); send(8'h51);
        idle(4);
        chk("b2b count", ev_cnt - c0, 2);
        chk("b2b note", note_o, 65);
        chk("b2b vel", vel_o, 81);
        chk("b2b rate", cyc_o, 4480);

        c0 = ev_cnt;
        f0 = f_cnt;
        send(8'h91); send(8'h3C); send(8'h64);
        idle(4);
        chk("filter other chan", f_cnt - f0, 0);
        chk("omni other chan", ev_cnt - c0, 1);

        c0 = ev_cnt;
        f0 = f_cnt;
        send(8'hC2); send(8'h05); send(8'h3C); send(8'h64);
        idle(4);
        chk("pgm change filt", f_cnt - f0, 0);
        chk("pgm change omni", ev_cnt - c0, 0);

        send(8'h92); send(8'h3C); send(8'h64);
        chk("filter match early", f_vld, 0);
        @(negedge clk);
        chk("filter match valid", f_vld, 1);
        chk("filter match on", f_on, 1);
        chk("filter match note", f_note, 60);
        chk("filter match rate", f_cyc, 5984);
        idle(2);

        c0 = ev_cnt;
        send(8'h90); send(8'h3C);
        rst_n = 1'b0;
        #1;
        chk("async rst valid", vld_o, 0);
        chk("async rst on", on_o, 0);
        chk("async rst note", note_o, 0);
        chk("async rst vel", vel_o, 0);
        chk("async rst rate", cyc_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        send(8'h64);
        idle(4);
        chk("post rst no event", ev_cnt - c0, 0);
        chk("post rst note", note_o, 0);
        chk("post rst rate", cyc_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
